// File: rtl/sccb_cfg_sequencer_if.sv
// Command/response link between the config sequencer and the SCCB byte master.
interface sccb_cfg_sequencer_if;
  logic       i2c_start;
  logic       i2c_stop;
  logic [7:0] i2c_wr_data;
  logic [1:0] i2c_ack;
  logic [3:0] i2c_state;

  // Sequencer side: issues commands, observes ack/state.
  modport master (
    output i2c_start,
    output i2c_stop,
    output i2c_wr_data,
    input  i2c_ack,
    input  i2c_state
  );

  // Byte-master side: consumes commands, reports ack/state.
  modport slave (
    input  i2c_start,
    input  i2c_stop,
    input  i2c_wr_data,
    output i2c_ack,
    output i2c_state
  );
endinterface

// File: rtl/sccb_cfg_sequencer.sv
// Walks the camera register table and issues each entry as a 3-byte SCCB write.
module sccb_cfg_sequencer #(
  parameter int unsigned CLK_HZ     = 100_000_000,
  parameter logic [7:0]  DEV_ADDR   = 8'h42,
  parameter int unsigned GAP_CYCLES = 1000,
  parameter int unsigned MAX_RETRY  = 3,
  parameter int unsigned ROM_DEPTH  = 64
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         go,
  output logic                         busy,
  output logic                         done,
  output logic                         err,
  output logic [$clog2(ROM_DEPTH)-1:0] entry_idx,
  sccb_cfg_sequencer_if.master         bus
);

  localparam int unsigned IDX_W     = $clog2(ROM_DEPTH);
  localparam int unsigned MS_CYCLES = CLK_HZ / 1000;
  localparam int unsigned DLY_MAX   = 255 * MS_CYCLES;
  localparam int unsigned CNT_MAX   = (DLY_MAX > GAP_CYCLES) ? DLY_MAX : GAP_CYCLES;
  localparam int unsigned CNT_W     = $clog2(CNT_MAX + 1);
  localparam int unsigned RTY_W     = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [15:0] END_MARK  = 16'hFFFF;
  localparam logic [7:0]  DELAY_TAG = 8'hFE;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_LAUNCH, S_XFER, S_WAIT_IDLE, S_GAP, S_DELAY, S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [1:0]         byte_q, byte_d;
  logic [RTY_W-1:0]   retry_q, retry_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ok_q, ok_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               err_q, err_d;

  // Register table: {hi, lo}; FFFF ends the sequence, hi=FE means wait lo ms.
  function automatic logic [15:0] rom(input logic [IDX_W-1:0] idx);
    case (int'(idx))
      0:       rom = 16'h1280;  // COM7 soft reset
      1:       rom = 16'hFE0A;  // 10 ms settle
      2:       rom = 16'h1204;  // COM7 RGB output
      3:       rom = 16'h40D0;  // COM15 RGB565, full range
      4:       rom = 16'h8C00;  // RGB444 off
      5:       rom = 16'hFE00;  // zero-length delay
      6:       rom = 16'h3A04;  // TSLB
      default: rom = END_MARK;
    endcase
  endfunction

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      byte_q  <= '0;
      retry_q <= '0;
      cnt_q   <= '0;
      ok_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      byte_q  <= byte_d;
      retry_q <= retry_d;
      cnt_q   <= cnt_d;
      ok_q    <= ok_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // Next-state logic; bus-side outputs are decoded from state so start, stop
  // and next-byte data line up with the master's ack tick.
  always_comb begin
    logic [15:0] entry;
    logic [7:0]  hi;
    logic [7:0]  lo;
    logic        tick;
    logic        nack;

    state_d         = state_q;
    idx_d           = idx_q;
    byte_d          = byte_q;
    retry_d         = retry_q;
    cnt_d           = cnt_q;
    ok_d            = ok_q;
    busy_d          = busy_q;
    done_d          = 1'b0;
    err_d           = err_q;
    bus.i2c_start   = 1'b0;
    bus.i2c_stop    = 1'b0;
    bus.i2c_wr_data = 8'h00;

    entry = rom(idx_q);
    hi    = entry[15:8];
    lo    = entry[7:0];
    tick  = bus.i2c_ack[1];
    nack  = bus.i2c_ack[1] & ~bus.i2c_ack[0];

    case (state_q)
      S_IDLE: begin
        if (go) begin
          idx_d   = '0;
          retry_d = '0;
          err_d   = 1'b0;
          busy_d  = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        if (entry == END_MARK || idx_q == IDX_W'(ROM_DEPTH - 1)) begin
          state_d = S_DONE;
        end else if (hi == DELAY_TAG) begin
          cnt_d   = CNT_W'(32'(lo) * MS_CYCLES);
          state_d = S_DELAY;
        end else begin
          byte_d  = 2'd0;
          state_d = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        if (bus.i2c_state == 4'd0) begin
          bus.i2c_start   = 1'b1;
          bus.i2c_wr_data = DEV_ADDR;
          byte_d          = 2'd1;
          state_d         = S_XFER;
        end
      end
      S_XFER: begin
        // byte_idx counts bytes handed to the master; 3 means the value byte is on the bus.
        bus.i2c_wr_data = (byte_q == 2'd1) ? hi : lo;
        bus.i2c_stop    = (byte_q == 2'd3) | nack;
        if (tick) begin
          if (nack) begin
            ok_d    = 1'b0;
            state_d = S_WAIT_IDLE;
          end else if (byte_q == 2'd3) begin
            ok_d    = 1'b1;
            retry_d = '0;
            state_d = S_WAIT_IDLE;
          end else begin
            byte_d = byte_q + 2'd1;
          end
        end
      end
      S_WAIT_IDLE: begin
        if (bus.i2c_state == 4'd0) begin
          cnt_d   = CNT_W'(GAP_CYCLES);
          state_d = S_GAP;
        end
      end
      S_GAP: begin
        if (cnt_q == '0) begin
          state_d = S_FETCH;
          if (ok_q) begin
            idx_d = idx_q + IDX_W'(1);
          end else if (retry_q < RTY_W'(MAX_RETRY)) begin
            retry_d = retry_q + RTY_W'(1);
          end else begin
            err_d   = 1'b1;
            retry_d = '0;
            idx_d   = idx_q + IDX_W'(1);
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_DELAY: begin
        if (cnt_q == '0) begin
          idx_d   = idx_q + IDX_W'(1);
          state_d = S_FETCH;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_DONE: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign entry_idx = idx_q;

endmodule

// File: tb/tb_sccb_cfg_sequencer.sv
// Bench: sequencer + behavioural byte master/slave, scoreboarded against a table-walk model.
`timescale 1ns/1ps
module tb_sccb_cfg_sequencer;

  localparam int unsigned CLK_HZ   = 1_000_000;
  localparam int unsigned GAP      = 10;
  localparam int unsigned MAXR     = 3;
  localparam int          MS       = 1000;
  localparam int          BYTE_CYC = 8;
  localparam int          STOP_CYC = 4;
  localparam logic [8:0]  EV_STOP  = 9'h100;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       go    = 1'b0;
  logic       busy;
  logic       done;
  logic       err;
  logic [5:0] entry_idx;

  sccb_cfg_sequencer_if bus();

  sccb_cfg_sequencer #(
    .CLK_HZ     (CLK_HZ),
    .DEV_ADDR   (8'h42),
    .GAP_CYCLES (GAP),
    .MAX_RETRY  (MAXR),
    .ROM_DEPTH  (64)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .go        (go),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .entry_idx (entry_idx),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk_eq(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic chk_rng(input string name, input longint act, input longint lo, input longint hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s: got %0d expected in [%0d,%0d]", name, act, lo, hi);
    end
  endtask

  // Slave NACK rules: A = one (transaction, byte position); B = value byte whenever reg matches.
  int rule_a_txn = -1;
  int rule_a_pos = -1;
  int rule_b_reg = -1;

  function automatic bit nack_rule(input int t, input int p, input int regv);
    return (t == rule_a_txn && p == rule_a_pos) || (rule_b_reg >= 0 && p == 2 && regv == rule_b_reg);
  endfunction

  // Behavioural byte master + slave: logs every byte on the bus and every stop.
  int         cyc = 0;
  int         last_idle = 0;
  int         txn_no = 0;
  logic [3:0] m_state;
  logic [1:0] m_ack;
  int         m_cnt;
  int         m_pos;
  logic [7:0] m_reg;
  logic [8:0] act_q[$];

  assign bus.i2c_state = m_state;
  assign bus.i2c_ack   = m_ack;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_state <= 4'd0;
      m_ack   <= 2'b00;
      m_cnt   <= 0;
      m_pos   <= 0;
      m_reg   <= 8'h00;
    end else begin
      m_ack <= 2'b00;
      case (m_state)
        4'd0: if (bus.i2c_start) begin
          act_q.push_back({1'b0, bus.i2c_wr_data});
          m_state <= 4'd1;
          m_cnt   <= BYTE_CYC;
          m_pos   <= 0;
        end
        4'd1: if (m_cnt == 0) begin
          m_ack   <= {1'b1, ~nack_rule(txn_no, m_pos, int'(m_reg))};
          m_state <= 4'd2;
        end else m_cnt <= m_cnt - 1;
        4'd2: if (bus.i2c_stop) begin
          act_q.push_back(EV_STOP);
          m_state <= 4'd3;
          m_cnt   <= STOP_CYC;
          txn_no  <= txn_no + 1;
        end else begin
          act_q.push_back({1'b0, bus.i2c_wr_data});
          if (m_pos == 0) m_reg <= bus.i2c_wr_data;
          m_pos   <= m_pos + 1;
          m_state <= 4'd1;
          m_cnt   <= BYTE_CYC;
        end
        default: if (m_cnt == 0) begin
          m_state   <= 4'd0;
          last_idle <= cyc;
        end else m_cnt <= m_cnt - 1;
      endcase
    end
  end

  // Model: expected bus events, launch entries, minimum idle gap before each launch, final err.
  logic [8:0] exp_q[$];
  int         exp_entry[$];
  int         exp_gap[$];
  bit         exp_err;
  bit         checking = 1'b0;
  logic       prev_start = 1'b0;

  function automatic logic [15:0] tb_rom(input int i);
    case (i)
      0:       return 16'h1280;
      1:       return 16'hFE0A;
      2:       return 16'h1204;
      3:       return 16'h40D0;
      4:       return 16'h8C00;
      5:       return 16'hFE00;
      6:       return 16'h3A04;
      default: return 16'hFFFF;
    endcase
  endfunction

  task automatic build_model();
    int         idx = 0;
    int         retry = 0;
    int         t = txn_no;
    int         extra = 0;
    bit         first = 1'b1;
    int         nack_at;
    logic [15:0] ent;
    logic [7:0] hi;
    logic [7:0] lo;
    logic [8:0] bv[3];
    exp_q.delete();
    exp_entry.delete();
    exp_gap.delete();
    act_q.delete();
    exp_err = 1'b0;
    while (idx < 63) begin
      ent = tb_rom(idx);
      if (ent == 16'hFFFF) break;
      hi = ent[15:8];
      lo = ent[7:0];
      if (hi == 8'hFE) begin
        extra += int'(lo) * MS;
        idx++;
      end else begin
        bv[0] = 9'h042;
        bv[1] = {1'b0, hi};
        bv[2] = {1'b0, lo};
        nack_at = -1;
        for (int p = 0; p < 3; p++) if (nack_at < 0 && nack_rule(t, p, int'(hi))) nack_at = p;
        for (int p = 0; p < 3; p++) if (nack_at < 0 || p <= nack_at) exp_q.push_back(bv[p]);
        exp_q.push_back(EV_STOP);
        exp_entry.push_back(idx);
        exp_gap.push_back(first ? -1 : int'(GAP) + extra);
        first = 1'b0;
        extra = 0;
        t++;
        if (nack_at < 0) begin
          retry = 0;
          idx++;
        end else if (retry < int'(MAXR)) begin
          retry++;
        end else begin
          exp_err = 1'b1;
          retry   = 0;
          idx++;
        end
      end
    end
  endtask

  // Compare process: bus events vs model, launch rules, done/busy relation.
  always @(negedge clk) begin
    logic [8:0] ev;
    int         g;
    if (rst_n && checking) begin
      while (act_q.size() > 0) begin
        ev = act_q.pop_front();
        if (exp_q.size() == 0) chk_eq("bus_event_unexpected", ev, -1);
        else chk_eq("bus_event", ev, exp_q.pop_front());
      end
      if (bus.i2c_start) begin
        chk_eq("start_when_idle", bus.i2c_state, 0);
        chk_eq("start_single_cycle", prev_start, 0);
        if (exp_entry.size() == 0) begin
          chk_eq("launch_unexpected", entry_idx, -1);
        end else begin
          chk_eq("launch_entry", entry_idx, exp_entry.pop_front());
          g = exp_gap.pop_front();
          if (g >= 0) chk_rng("launch_gap", cyc - last_idle, g, g + 20);
        end
      end
      if (done) chk_eq("busy_at_done", busy, 0);
    end
    prev_start = bus.i2c_start;
  end

  task automatic run(input string tag, input int a_rel, input int a_pos, input int b_reg,
                     input bit poke, input int lit_events, input bit lit_err);
    bit         seen = 1'b0;
    logic [5:0] saved;
    rule_a_txn = (a_rel < 0) ? -1 : txn_no + a_rel;
    rule_a_pos = a_pos;
    rule_b_reg = b_reg;
    build_model();
    chk_eq({tag, "_model_events"}, exp_q.size(), lit_events);
    chk_eq({tag, "_model_err"}, exp_err, lit_err);
    chk_eq({tag, "_model_head0"}, exp_q[0], 9'h042);
    chk_eq({tag, "_model_head1"}, exp_q[1], 9'h012);
    chk_eq({tag, "_model_head2"}, exp_q[2], 9'h080);
    chk_eq({tag, "_model_head3"}, exp_q[3], EV_STOP);
    chk_eq({tag, "_idle_before_go"}, busy, 0);
    @(negedge clk) go = 1'b1;
    @(negedge clk) go = 1'b0;
    chk_eq({tag, "_busy_after_go"}, busy, 1);
    chk_eq({tag, "_idx_after_go"}, entry_idx, 0);
    chk_eq({tag, "_err_after_go"}, err, 0);
    for (int i = 0; i < 30000 && !seen; i++) begin
      @(negedge clk);
      if (poke && i == 300) begin
        saved = entry_idx;
        chk_eq({tag, "_idx_in_delay"}, saved, 1);
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        chk_eq({tag, "_go_ignored_idx"}, entry_idx, saved);
        chk_eq({tag, "_go_ignored_busy"}, busy, 1);
      end
      if (done) seen = 1'b1;
    end
    chk_eq({tag, "_done_seen"}, seen, 1);
    chk_eq({tag, "_err_final"}, err, lit_err);
    @(negedge clk);
    chk_eq({tag, "_done_one_cycle"}, done, 0);
    chk_eq({tag, "_busy_final"}, busy, 0);
    @(negedge clk);
    chk_eq({tag, "_bus_events_left"}, exp_q.size(), 0);
    chk_eq({tag, "_launches_left"}, exp_entry.size(), 0);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    bit found = 1'b0;
    repeat (3) @(negedge clk);
    chk_eq("rst_busy", busy, 0);
    chk_eq("rst_done", done, 0);
    chk_eq("rst_err", err, 0);
    chk_eq("rst_entry_idx", entry_idx, 0);
    chk_eq("rst_start", bus.i2c_start, 0);
    chk_eq("rst_stop", bus.i2c_stop, 0);
    chk_eq("rst_wr_data", bus.i2c_wr_data, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checking = 1'b1;

    run("all_ack",     -1, -1, -1,    1'b1, 20, 1'b0);
    run("nack_once",    1,  1, -1,    1'b0, 23, 1'b0);
    run("nack_always", -1, -1, 'h40,  1'b0, 32, 1'b1);

    // Reset mid-transfer; the go also clears the sticky error from the previous run.
    rule_a_txn = -1;
    rule_b_reg = -1;
    build_model();
    @(negedge clk) go = 1'b1;
    @(negedge clk) go = 1'b0;
    chk_eq("go_clears_err", err, 0);
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      if (bus.i2c_state != 4'd0) found = 1'b1;
    end
    chk_eq("xfer_reached", found, 1);
    repeat (3) @(negedge clk);
    checking = 1'b0;
    rst_n = 1'b0;
    #1;
    chk_eq("xfer_rst_busy", busy, 0);
    chk_eq("xfer_rst_done", done, 0);
    chk_eq("xfer_rst_err", err, 0);
    chk_eq("xfer_rst_entry_idx", entry_idx, 0);
    chk_eq("xfer_rst_start", bus.i2c_start, 0);
    chk_eq("xfer_rst_stop", bus.i2c_stop, 0);
    chk_eq("xfer_rst_wr_data", bus.i2c_wr_data, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk_eq("post_rst_busy", busy, 0);
    chk_eq("post_rst_start", bus.i2c_start, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
